// File: rtl/scope_frame_sequencer.sv
// Per-frame XY scope driver: snapshots 8 object positions, then blanks/moves/settles/draws each enabled object.
// Define SCOPE_FRAME_MARKER_EN to add a reference dot at the origin after object 7.
module scope_frame_sequencer #(
  parameter int SETTLE_CYCLES = 16,
  parameter int DWELL_CYCLES  = 64,
  parameter int GAP_CYCLES    = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_enable,
  input  logic        pos_stable,
  input  logic [55:0] x_pos_flat,
  input  logic [47:0] y_pos_flat,
  input  logic [7:0]  obj_mask,
  output logic [7:0]  x_dac,
  output logic [7:0]  y_dac,
  output logic        z_blank,
  output logic        frame_start,
  output logic [2:0]  obj_index
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MOVE,
    DRAW,
`ifdef SCOPE_FRAME_MARKER_EN
    MARK,
`endif
    GAP
  } state_t;

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] DWELL_LAST  = 16'(DWELL_CYCLES - 1);
  localparam logic [15:0] GAP_LAST    = 16'(GAP_CYCLES - 1);

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  idx_n, nidx;
  logic [7:0]  x_n, y_n;
  logic        advance;
  logic [6:0]  x_snap [8];
  logic [5:0]  y_snap [8];
  logic [7:0]  mask_snap;
`ifdef SCOPE_FRAME_MARKER_EN
  logic        mark_lit, mark_lit_n;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      obj_index <= '0;
      x_dac     <= '0;
      y_dac     <= '0;
      mask_snap <= '0;
      for (int i = 0; i < 8; i++) begin
        x_snap[i] <= '0;
        y_snap[i] <= '0;
      end
`ifdef SCOPE_FRAME_MARKER_EN
      mark_lit  <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      obj_index <= idx_n;
      x_dac     <= x_n;
      y_dac     <= y_n;
`ifdef SCOPE_FRAME_MARKER_EN
      mark_lit  <= mark_lit_n;
`endif
      // The bank is only ever sampled here, so a frame is immune to mid-frame writes.
      if (state == LOAD) begin
        mask_snap <= obj_mask;
        for (int i = 0; i < 8; i++) begin
          x_snap[i] <= x_pos_flat[i*7 +: 7];
          y_snap[i] <= y_pos_flat[i*6 +: 6];
        end
      end
    end
  end

  // frame_enable and pos_stable are plain levels: a frame starts on any cycle where
  // both are high while idle or at the end of GAP; there is no acknowledge back.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = obj_index;
    x_n     = x_dac;
    y_n     = y_dac;
    advance = 1'b0;
    nidx    = obj_index + 3'd1;
`ifdef SCOPE_FRAME_MARKER_EN
    mark_lit_n = mark_lit;
`endif
    case (state)
      IDLE: begin
        if (frame_enable && pos_stable) state_n = LOAD;
      end
      LOAD: begin
        idx_n   = '0;
        cnt_n   = '0;
        state_n = MOVE;
        // Snapshot lands on this same edge, so object 0 comes straight from the inputs.
        if (obj_mask[0]) begin
          x_n = {x_pos_flat[6:0], 1'b0};
          y_n = {y_pos_flat[5:0], 2'b00};
        end
      end
      MOVE: begin
        if (!mask_snap[obj_index]) begin
          advance = 1'b1;
        end else if (cnt == SETTLE_LAST) begin
          cnt_n   = '0;
          state_n = DRAW;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      DRAW: begin
        if (cnt == DWELL_LAST) begin
          cnt_n   = '0;
          advance = 1'b1;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
`ifdef SCOPE_FRAME_MARKER_EN
      MARK: begin
        if (!mark_lit) begin
          if (cnt == SETTLE_LAST) begin
            cnt_n      = '0;
            mark_lit_n = 1'b1;
          end else begin
            cnt_n = cnt + 16'd1;
          end
        end else if (cnt == DWELL_LAST) begin
          cnt_n      = '0;
          mark_lit_n = 1'b0;
          state_n    = GAP;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
`endif
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_n   = '0;
          state_n = (frame_enable && pos_stable) ? LOAD : IDLE;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    // DACs move on the same edge that leaves DRAW, so the beam is already blanked.
    if (advance) begin
      if (obj_index != 3'd7) begin
        idx_n   = nidx;
        state_n = MOVE;
        if (mask_snap[nidx]) begin
          x_n = {x_snap[nidx], 1'b0};
          y_n = {y_snap[nidx], 2'b00};
        end
      end else begin
`ifdef SCOPE_FRAME_MARKER_EN
        state_n    = MARK;
        x_n        = '0;
        y_n        = '0;
        mark_lit_n = 1'b0;
`else
        state_n = GAP;
`endif
      end
    end
  end

`ifdef SCOPE_FRAME_MARKER_EN
  assign z_blank = !((state == DRAW) || ((state == MARK) && mark_lit));
`else
  assign z_blank = !(state == DRAW);
`endif
  assign frame_start = (state == LOAD);

endmodule
